// File: rtl/sdram_rr_arbiter_if.sv
// Avalon-MM master bus between the round-robin arbiter and SDRAM s1.
// master: arbiter side (strobes, address, data out); slave: controller side.
interface sdram_rr_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable_n;
  logic              chipselect;
  logic [DATA_W-1:0] writedata;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, byteenable_n, chipselect,
    output writedata, read_n, write_n,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable_n, chipselect,
    input  writedata, read_n, write_n,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// N-channel round-robin front end to the Avalon-MM SDRAM controller.
// Clients: i_addr/i_read/i_write/i_wdata/i_be in; o_rdata/o_done/o_err/
// o_busy/o_grant out. SDRAM side on the avm master modport.
module sdram_rr_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 4,
  parameter int RD_TIMEOUT = 64,
  localparam int BE_W = DATA_W / 8,
  localparam int GR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [NUM_CH-1:0]        i_read,
  input  logic [NUM_CH-1:0]        i_write,
  input  logic [NUM_CH*DATA_W-1:0] i_wdata,
  input  logic [NUM_CH*BE_W-1:0]   i_be,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [NUM_CH-1:0]        o_done,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [GR_W-1:0]          o_grant,
  sdram_rr_arbiter_if.master       avm
);

  localparam int TM_W = $clog2(RD_TIMEOUT + 1);
  localparam int GP_W =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TM_W-1:0] TM_LAST =
    TM_W'(RD_TIMEOUT - 1);
  localparam logic [GP_W-1:0] GP_LAST =
    GP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDWAIT,
    GAP
  } state_t;

  // Where a finished access goes: straight back to IDLE when no gap.
  localparam state_t FIN_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t              r_state;
  logic [GR_W-1:0]     r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be_n;
  logic                r_op_wr;
  logic                r_rd_n;
  logic                r_wr_n;
  logic [DATA_W-1:0]   r_rdata;
  logic [NUM_CH-1:0]   r_done;
  logic                r_err;
  logic [TM_W-1:0]     r_tmr;
  logic [GP_W-1:0]     r_gap;

  logic [NUM_CH-1:0]   w_req;
  logic                w_hit;
  logic [GR_W-1:0]     w_sel;
  logic [NUM_CH-1:0]   w_onehot;

  // A channel whose done is high this cycle may still show its
  // request; masking it stops the same access being issued twice.
  assign w_req    = (i_read | i_write) & ~r_done;
  assign w_onehot = NUM_CH'(1) << r_grant;

  always_comb begin
    logic [GR_W-1:0] idx;
    w_hit = 1'b0;
    w_sel = r_grant;
    idx   = r_grant;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = GR_W'((int'(r_grant) + i) % NUM_CH);
      if (!w_hit && w_req[idx]) begin
        w_hit = 1'b1;
        w_sel = idx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_grant <= GR_W'(NUM_CH - 1);
      r_addr  <= '0;
      r_wdata <= '0;
      r_be_n  <= '1;
      r_op_wr <= 1'b0;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_rdata <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_tmr   <= '0;
      r_gap   <= '0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_grant <= w_sel;
            r_addr  <= i_addr[int'(w_sel)*ADDR_W +: ADDR_W];
            r_wdata <= i_wdata[int'(w_sel)*DATA_W +: DATA_W];
            r_be_n  <= ~i_be[int'(w_sel)*BE_W +: BE_W];
            r_op_wr <= i_write[w_sel];
            r_wr_n  <= ~i_write[w_sel];
            r_rd_n  <= i_write[w_sel];
            r_state <= CMD;
          end
        end
        CMD: begin
          if (!avm.waitrequest) begin
            r_rd_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_be_n <= '1;
            r_tmr  <= '0;
            r_gap  <= '0;
            if (r_op_wr) begin
              r_done  <= w_onehot;
              r_state <= FIN_ST;
            end else if (avm.readdatavalid) begin
              r_rdata <= avm.readdata;
              r_done  <= w_onehot;
              r_state <= FIN_ST;
            end else begin
              r_state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (avm.readdatavalid) begin
            r_rdata <= avm.readdata;
            r_done  <= w_onehot;
            r_state <= FIN_ST;
          end else if (r_tmr == TM_LAST) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_done  <= w_onehot;
            r_state <= FIN_ST;
          end else begin
            r_tmr <= r_tmr + TM_W'(1);
          end
        end
        GAP: begin
          if (r_gap == GP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + GP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rdata  = r_rdata;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_busy   = (r_state != IDLE);
  assign o_grant  = r_grant;

  assign avm.address      = r_addr;
  assign avm.byteenable_n = r_be_n;
  assign avm.chipselect   = 1'b1;
  assign avm.writedata    = r_wdata;
  assign avm.read_n       = r_rd_n;
  assign avm.write_n      = r_wr_n;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: main DUT with a 4-cycle gap,
// second DUT with no gap for the done-cycle re-grant mask.
module tb_sdram_rr_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int BW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    rd, wr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH*BW-1:0] be;
  logic [DW-1:0]     rdata;
  logic [NCH-1:0]    done;
  logic              err, busy;
  logic [0:0]        grant;

  logic [NCH*AW-1:0] g_addr;
  logic [NCH-1:0]    g_rd, g_wr;
  logic [NCH*DW-1:0] g_wdata;
  logic [NCH*BW-1:0] g_be;
  logic [DW-1:0]     g_rdata;
  logic [NCH-1:0]    g_done;
  logic              g_err, g_busy;
  logic [0:0]        g_grant;

  sdram_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sdram_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) gbus ();

  sdram_rr_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
    .GAP_CYCLES(4), .RD_TIMEOUT(64)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_addr(addr), .i_read(rd), .i_write(wr),
    .i_wdata(wdata), .i_be(be),
    .o_rdata(rdata), .o_done(done), .o_err(err),
    .o_busy(busy), .o_grant(grant),
    .avm(bus)
  );

  sdram_rr_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
    .GAP_CYCLES(0), .RD_TIMEOUT(8)
  ) u_g0 (
    .i_clk(clk), .i_rst(rst),
    .i_addr(g_addr), .i_read(g_rd), .i_write(g_wr),
    .i_wdata(g_wdata), .i_be(g_be),
    .o_rdata(g_rdata), .o_done(g_done), .o_err(g_err),
    .o_busy(g_busy), .o_grant(g_grant),
    .avm(gbus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 100 && busy !== 1'b0; k++) step();
    step();
    chk(tag, 64'(busy), 64'(0));
  endtask

  logic [0:0] gseq [4];
  int ngr;
  int ncyc;

  initial begin
    rd = '0; wr = '0; addr = '0; wdata = '0; be = '0;
    g_rd = '0; g_wr = '0; g_addr = '0; g_wdata = '0; g_be = '0;
    bus.readdata = '0; bus.readdatavalid = 1'b0;
    bus.waitrequest = 1'b0;
    gbus.readdata = '0; gbus.readdatavalid = 1'b0;
    gbus.waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) gseq[i] = 1'bx;

    repeat (2) step();
    chk("rst_rd_n", 64'(bus.read_n), 64'(1));
    chk("rst_wr_n", 64'(bus.write_n), 64'(1));
    chk("rst_be_n", 64'(bus.byteenable_n), 64'hF);
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant), 64'(1));
    chk("rst_addr", 64'(bus.address), 64'(0));
    chk("rst_wdata", 64'(bus.writedata), 64'(0));
    chk("rst_cs", 64'(bus.chipselect), 64'(1));
    rst = 1'b0;

    // ch0 single write, no wait
    addr[0 +: AW]  = 23'h10;
    wdata[0 +: DW] = 32'hDEADBEEF;
    be[0 +: BW]    = 4'hF;
    wr = 2'b01;
    step();
    chk("t1_wr_n", 64'(bus.write_n), 64'(0));
    chk("t1_rd_n", 64'(bus.read_n), 64'(1));
    chk("t1_addr", 64'(bus.address), 64'h10);
    chk("t1_wdata", 64'(bus.writedata), 64'hDEADBEEF);
    chk("t1_be_n", 64'(bus.byteenable_n), 64'h0);
    chk("t1_grant", 64'(grant), 64'(0));
    chk("t1_nodone", 64'(done), 64'(0));
    step();
    chk("t1_done", 64'(done), 64'b01);
    chk("t1_err", 64'(err), 64'(0));
    chk("t1_wr_n_hi", 64'(bus.write_n), 64'(1));
    chk("t1_be_idle", 64'(bus.byteenable_n), 64'hF);
    wr = '0;
    step();
    chk("t1_pulse", 64'(done), 64'(0));
    step(); step();
    chk("t1_gap_busy", 64'(busy), 64'(1));
    step();
    chk("t1_gap_end", 64'(busy), 64'(0));

    // ch1 read: 3 wait cycles, data 2 cycles after accept
    addr[AW +: AW] = 23'h20;
    rd = 2'b10;
    bus.waitrequest = 1'b1;
    step();
    chk("t2_rd_n", 64'(bus.read_n), 64'(0));
    chk("t2_addr", 64'(bus.address), 64'h20);
    chk("t2_grant", 64'(grant), 64'(1));
    repeat (3) step();
    chk("t2_hold", 64'(bus.read_n), 64'(0));
    bus.waitrequest = 1'b0;
    step();
    chk("t2_acc", 64'(bus.read_n), 64'(1));
    chk("t2_busy", 64'(busy), 64'(1));
    step();
    chk("t2_nodone", 64'(done), 64'(0));
    bus.readdata = 32'h12345678;
    bus.readdatavalid = 1'b1;
    step();
    chk("t2_rdata", 64'(rdata), 64'h12345678);
    chk("t2_done", 64'(done), 64'b10);
    chk("t2_err", 64'(err), 64'(0));
    bus.readdatavalid = 1'b0;
    rd = '0;
    wait_idle("t2_idle");

    // both channels write continuously: grants alternate
    addr[0 +: AW] = 23'h40;
    addr[AW +: AW] = 23'h41;
    be = '1;
    wr = 2'b11;
    ngr = 0;
    for (int k = 0; k < 200 && ngr < 4; k++) begin
      step();
      if (bus.write_n == 1'b0) begin
        gseq[ngr] = grant;
        ngr++;
      end
    end
    wr = '0;
    chk("t3_count", 64'(ngr), 64'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_g%0d", i), 64'(gseq[i]), 64'(i % 2));
    wait_idle("t3_idle");

    // ch0 read with no readdatavalid: timeout
    addr[0 +: AW] = 23'h55;
    rd = 2'b01;
    step();
    chk("t4_rd_n", 64'(bus.read_n), 64'(0));
    step();
    chk("t4_acc", 64'(bus.read_n), 64'(1));
    ncyc = 0;
    while (done == '0 && ncyc < 200) begin
      step();
      ncyc++;
    end
    chk("t4_lat", 64'(ncyc), 64'(64));
    chk("t4_done", 64'(done), 64'b01);
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_rdata", 64'(rdata), 64'(0));
    rd = '0;
    bus.readdata = 32'hAAAA5555;
    bus.readdatavalid = 1'b1;
    step();
    bus.readdatavalid = 1'b0;
    chk("t4_stray_rd", 64'(rdata), 64'(0));
    chk("t4_stray_dn", 64'(done), 64'(0));
    chk("t4_stray_er", 64'(err), 64'(0));
    wait_idle("t4_idle");

    // ch0 read+write together: write first, read stays pending
    addr[0 +: AW]  = 23'h33;
    wdata[0 +: DW] = 32'hCAFEF00D;
    be[0 +: BW]    = 4'h3;
    rd = 2'b01;
    wr = 2'b01;
    step();
    chk("t5_wr_n", 64'(bus.write_n), 64'(0));
    chk("t5_rd_n", 64'(bus.read_n), 64'(1));
    chk("t5_be_n", 64'(bus.byteenable_n), 64'hC);
    chk("t5_wdata", 64'(bus.writedata), 64'hCAFEF00D);
    step();
    chk("t5_wdone", 64'(done), 64'b01);
    wr = '0;
    for (int k = 0; k < 20 && bus.read_n !== 1'b0; k++) step();
    chk("t5_rd_issue", 64'(bus.read_n), 64'(0));
    chk("t5_rd_be_n", 64'(bus.byteenable_n), 64'hC);
    bus.readdata = 32'h0BADCAFE;
    bus.readdatavalid = 1'b1;
    step();
    bus.readdatavalid = 1'b0;
    chk("t5_rdone", 64'(done), 64'b01);
    chk("t5_rdata", 64'(rdata), 64'h0BADCAFE);
    chk("t5_rerr", 64'(err), 64'(0));
    rd = '0;
    wait_idle("t5_idle");

    // reset during RDWAIT
    addr[AW +: AW] = 23'h66;
    rd = 2'b10;
    step();
    chk("t6_rd_n", 64'(bus.read_n), 64'(0));
    repeat (3) step();
    chk("t6_busy", 64'(busy), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_rd_n", 64'(bus.read_n), 64'(1));
    chk("t6_rst_wr_n", 64'(bus.write_n), 64'(1));
    chk("t6_rst_done", 64'(done), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_grant", 64'(grant), 64'(1));
    rd = 2'b11;
    step();
    rst = 1'b0;
    step();
    chk("t6_grant0", 64'(grant), 64'(0));
    chk("t6_rd_n0", 64'(bus.read_n), 64'(0));
    rd = '0;
    bus.readdata = 32'h1;
    bus.readdatavalid = 1'b1;
    step();
    bus.readdatavalid = 1'b0;
    wait_idle("t6_idle");

    // no-gap DUT: request still high at its done cycle is masked
    g_addr[0 +: AW]  = 23'h7;
    g_wdata[0 +: DW] = 32'h0000F00D;
    g_be[0 +: BW]    = 4'hF;
    g_wr = 2'b01;
    step();
    chk("g_wr_n", 64'(gbus.write_n), 64'(0));
    step();
    chk("g_done", 64'(g_done), 64'b01);
    chk("g_busy_dn", 64'(g_busy), 64'(0));
    step();
    chk("g_noregrant", 64'(g_busy), 64'(0));
    chk("g_wr_n_hi", 64'(gbus.write_n), 64'(1));
    chk("g_pulse", 64'(g_done), 64'(0));
    step();
    chk("g_regrant", 64'(g_busy), 64'(1));
    chk("g_wr_n2", 64'(gbus.write_n), 64'(0));
    g_wr = '0;
    step();
    chk("g_done2", 64'(g_done), 64'b01);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
